// File: rtl/axi_pkg.sv
// Shared AXI encodings, tester FSM states and the memory test pattern.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5
  } tester_state_e;

  // Beat i of pass p: i + p*0x01010101, built from shifts instead of a multiplier.
  function automatic logic [31:0] mem_test_pattern(input logic [31:0] i, input logic [31:0] p);
    return i + p + (p << 8) + (p << 16) + (p << 24);
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat-within-burst and burst-within-window index counter shared by W and R phases.
module axi_beat_counter #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned NBURSTS   = 256,
  parameter int unsigned BEAT_W    = 2,
  parameter int unsigned BURST_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               beat_i,
  input  logic               burst_i,
  output logic [BEAT_W-1:0]  beat_o,
  output logic [BURST_W-1:0] burst_o,
  output logic               last_beat_o,
  output logic               last_burst_o
);

  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  assign last_beat_o  = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_burst_o = (burst_q == BURST_W'(NBURSTS - 1));
  assign beat_o       = beat_q;
  assign burst_o      = burst_q;

  // Next index: clear wins; beat wraps after the last beat, burst after the last burst.
  always_comb begin
    beat_d  = beat_q;
    burst_d = burst_q;
    if (clear_i) begin
      beat_d  = '0;
      burst_d = '0;
    end else begin
      if (beat_i)  beat_d  = last_beat_o  ? '0 : beat_q + 1'b1;
      if (burst_i) burst_d = last_burst_o ? '0 : burst_q + 1'b1;
    end
  end

  // Index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      burst_q <= '0;
    end else begin
      beat_q  <= beat_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: rtl/axi_mem_tester.sv
// AXI4 burst master: writes a pass-dependent pattern over a window, reads it back, counts errors.
module axi_mem_tester
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned WORDS     = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                calib_done,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [31:0]         pass_count,
  output logic [31:0]         err_count,
  output logic [DATA_W-1:0]   last_rdata,
  output logic [2:0]          state_value
);

  localparam int unsigned BYTES       = DATA_W / 8;
  localparam int unsigned NBURSTS     = WORDS / BURST_LEN;
  localparam int unsigned BURST_BYTES = BURST_LEN * BYTES;
  localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned BURST_W     = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;

  tester_state_e      state_q, state_d;
  logic [31:0]        pass_q;
  logic [31:0]        err_q;
  logic [DATA_W-1:0]  last_rdata_q;

  logic               cnt_clear, cnt_beat, cnt_burst;
  logic               pass_inc, err_hit;
  logic [BEAT_W-1:0]  beat;
  logic [BURST_W-1:0] burst;
  logic               last_beat, last_burst;
  logic [31:0]        beat_idx;
  logic [ADDR_W-1:0]  burst_addr;
  logic [DATA_W-1:0]  exp_data;

  axi_beat_counter #(
    .BURST_LEN (BURST_LEN),
    .NBURSTS   (NBURSTS),
    .BEAT_W    (BEAT_W),
    .BURST_W   (BURST_W)
  ) u_cnt (
    .clk_i        (clk),
    .rst_ni       (rst),
    .clear_i      (cnt_clear),
    .beat_i       (cnt_beat),
    .burst_i      (cnt_burst),
    .beat_o       (beat),
    .burst_o      (burst),
    .last_beat_o  (last_beat),
    .last_burst_o (last_burst)
  );

  assign beat_idx   = 32'(burst) * 32'(BURST_LEN) + 32'(beat);
  assign burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst) * ADDR_W'(BURST_BYTES);
  assign exp_data   = DATA_W'(mem_test_pattern(beat_idx, pass_q));

  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'($clog2(BYTES));
  assign m_axi_arsize  = 3'($clog2(BYTES));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_wstrb   = '1;

  // Handshake signals are pure decodes of the registered state; address and
  // data come from registered indices, so they hold while a beat is stalled.
  assign m_axi_awvalid = (state_q == S_AW);
  assign m_axi_wvalid  = (state_q == S_W);
  assign m_axi_bready  = (state_q == S_B);
  assign m_axi_arvalid = (state_q == S_AR);
  assign m_axi_rready  = (state_q == S_R);
  assign m_axi_awaddr  = (state_q == S_AW) ? burst_addr : '0;
  assign m_axi_araddr  = (state_q == S_AR) ? burst_addr : '0;
  assign m_axi_wdata   = (state_q == S_W) ? exp_data : '0;
  assign m_axi_wlast   = (state_q == S_W) && last_beat;

  assign pass_count  = pass_q;
  assign err_count   = err_q;
  assign last_rdata  = last_rdata_q;
  assign state_value = state_q;

  // Next state, counter control and per-beat error detection.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_beat  = 1'b0;
    cnt_burst = 1'b0;
    pass_inc  = 1'b0;
    err_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: if (en && calib_done) begin
        state_d   = S_AW;
        cnt_clear = 1'b1;
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: if (m_axi_wready) begin
        cnt_beat = 1'b1;
        if (last_beat) state_d = S_B;
      end
      S_B: if (m_axi_bvalid) begin
        err_hit = (m_axi_bresp != RESP_OKAY);
        if (last_burst) begin
          state_d   = S_AR;
          cnt_clear = 1'b1;
        end else begin
          state_d   = S_AW;
          cnt_burst = 1'b1;
        end
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: if (m_axi_rvalid) begin
        cnt_beat = 1'b1;
        err_hit  = (m_axi_rdata != exp_data) || (m_axi_rresp != RESP_OKAY) ||
                   (m_axi_rlast != last_beat);
        if (last_beat) begin
          if (!last_burst) begin
            state_d   = S_AR;
            cnt_burst = 1'b1;
          end else begin
            state_d   = en ? S_AW : S_IDLE;
            cnt_clear = 1'b1;
            pass_inc  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, pass/error counters and captured read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pass_q       <= '0;
      err_q        <= '0;
      last_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (pass_inc) pass_q <= pass_q + 1'b1;
      if (err_hit && (err_q != '1)) err_q <= err_q + 1'b1;
      if ((state_q == S_R) && m_axi_rvalid) last_rdata_q <= m_axi_rdata;
    end
  end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Directed bench for axi_mem_tester with an 8-word AXI memory model and stall/fault injection.
module tb_axi_mem_tester;

  logic        clk = 1'b0;
  logic        rst, en, calib_done;
  logic [28:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [31:0] pass_count, err_count, last_rdata;
  logic [2:0]  state_value;

  int checks = 0;
  int errors = 0;

  // memory model state and fault-injection controls
  logic [31:0] mem [8];
  logic        stall = 1'b0, inj_corrupt = 1'b0, inj_slverr = 1'b0, inj_droprlast = 1'b0;
  logic        rd5_seen = 1'b0;
  logic        b_pending, r_active;
  logic [28:0] w_burst_addr, b_addr, r_burst_addr;
  int          wptr, rptr, rbeat;

  // stability monitor state
  int          stab_seen = 0, stab_viol = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_wlast;
  logic [28:0] p_awaddr, p_araddr;
  logic [31:0] p_wdata;

  always #5 clk = ~clk;

  axi_mem_tester #(
    .ADDR_W    (29),
    .DATA_W    (32),
    .BURST_LEN (4),
    .BASE_ADDR (0),
    .WORDS     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .calib_done    (calib_done),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .pass_count    (pass_count),
    .err_count     (err_count),
    .last_rdata    (last_rdata),
    .state_value   (state_value)
  );

  // Slave model on the falling edge: each handshake set up here completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      b_pending = 1'b0; r_active = 1'b0;
      p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
      p_awr = 1'b0; p_wr = 1'b0; p_arr = 1'b0;
    end else begin
      // master side must hold valid and payload across a stalled cycle
      if (p_awv && !p_awr) begin
        stab_seen++;
        if (!(m_axi_awvalid && m_axi_awaddr == p_awaddr)) stab_viol++;
      end
      if (p_wv && !p_wr) begin
        stab_seen++;
        if (!(m_axi_wvalid && m_axi_wdata == p_wdata && m_axi_wlast == p_wlast)) stab_viol++;
      end
      if (p_arv && !p_arr) begin
        stab_seen++;
        if (!(m_axi_arvalid && m_axi_araddr == p_araddr)) stab_viol++;
      end

      m_axi_bvalid = b_pending;
      m_axi_bresp  = (b_pending && inj_slverr && b_addr == 29'h10) ? 2'b10 : 2'b00;
      if (m_axi_bvalid && m_axi_bready) b_pending = 1'b0;

      m_axi_wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axi_wvalid && m_axi_wready) begin
        mem[wptr] = m_axi_wdata;
        wptr = (wptr + 1) % 8;
        if (m_axi_wlast) begin
          b_pending = 1'b1;
          b_addr    = w_burst_addr;
        end
      end

      m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axi_awvalid && m_axi_awready) begin
        wptr         = int'(m_axi_awaddr[4:2]);
        w_burst_addr = m_axi_awaddr;
      end

      if (r_active) begin
        m_axi_rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_rdata  = mem[rptr] ^ {31'd0, (inj_corrupt && rptr == 5)};
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = (rbeat == 3) && !(inj_droprlast && r_burst_addr == 29'h0);
        if (m_axi_rvalid && m_axi_rready) begin
          if (rptr == 5) rd5_seen = 1'b1;
          rptr++;
          rbeat++;
          if (rbeat == 4) r_active = 1'b0;
        end
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end

      m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_axi_arvalid && m_axi_arready) begin
        rptr         = int'(m_axi_araddr[4:2]);
        rbeat        = 0;
        r_active     = 1'b1;
        r_burst_addr = m_axi_araddr;
      end

      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wlast = m_axi_wlast;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_passes(input int n, input int budget);
    logic [31:0] target;
    target = pass_count + 32'(n);
    for (int c = 0; c < budget && pass_count != target; c++) tick();
    check("pass_wait", 64'(pass_count), 64'(target));
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    for (int c = 0; c < budget && state_value != s; c++) tick();
    check("state_wait", 64'(state_value), 64'(s));
  endtask

  logic [31:0] e0, p0;

  initial begin
    rst = 1'b0; en = 1'b0; calib_done = 1'b0;
    #3;
    check("rst_state", 64'(state_value), 64'd0);
    check("rst_hs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, m_axi_wlast}), 64'd0);
    check("rst_addr", 64'({m_axi_awaddr, m_axi_araddr}), 64'd0);
    check("rst_wdata", 64'(m_axi_wdata), 64'd0);
    check("rst_cnt", 64'({pass_count, err_count}), 64'd0);
    check("rst_rdata", 64'(last_rdata), 64'd0);

    @(negedge clk);
    #2 rst = 1'b1; en = 1'b1;
    repeat (4) tick();
    check("calib_gate", 64'(state_value), 64'd0);

    // first write burst, cycle by cycle, with an always-ready slave
    calib_done = 1'b1;
    tick();
    check("aw0_state", 64'(state_value), 64'd1);
    check("aw0_addr", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, 29'h0}));
    check("aw_const", 64'({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_wstrb}), 64'({8'd3, 3'd2, 2'b01, 4'hF}));
    check("ar_const", 64'({m_axi_arlen, m_axi_arsize, m_axi_arburst}), 64'({8'd3, 3'd2, 2'b01}));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("w0_beat", 64'({state_value, m_axi_wvalid, m_axi_wlast, m_axi_wdata}),
            64'({3'd2, 1'b1, (i == 3), 32'(i)}));
    end
    tick();
    check("b0_state", 64'({state_value, m_axi_bready, m_axi_wvalid}), 64'({3'd3, 1'b1, 1'b0}));
    tick();
    check("aw1_addr", 64'({state_value, m_axi_awaddr}), 64'({3'd1, 29'h10}));
    tick();
    check("w1_beat0", 64'(m_axi_wdata), 64'd4);
    wait_state(3'd4, 20);
    check("ar0_addr", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, 29'h0}));
    wait_passes(1, 40);
    check("p1_err", 64'(err_count), 64'd0);
    check("p1_rdata", 64'(last_rdata), 64'd7);
    for (int i = 0; i < 8; i++) check("p1_mem", 64'(mem[i]), 64'(i));
    check("p2_restart", 64'({state_value, m_axi_awaddr}), 64'({3'd1, 29'h0}));
    wait_passes(1, 40);
    check("p2_mem0", 64'(mem[0]), 64'h0101_0101);
    check("p2_mem7", 64'(mem[7]), 64'h0101_0108);
    check("p2_rdata", 64'(last_rdata), 64'h0101_0108);
    check("p2_err", 64'(err_count), 64'd0);

    // random stalls on every channel
    stall = 1'b1;
    e0 = err_count;
    wait_passes(10, 4000);
    stall = 1'b0;
    check("stall_err", 64'(err_count), 64'(e0));
    check("stall_seen", 64'(stab_seen != 0), 64'd1);
    check("axi_stable", 64'(stab_viol), 64'd0);

    // SLVERR on write burst 1 plus a missing rlast on read burst 0
    inj_slverr = 1'b1; inj_droprlast = 1'b1;
    e0 = err_count;
    wait_passes(1, 60);
    inj_slverr = 1'b0; inj_droprlast = 1'b0;
    check("inj_err2", 64'(err_count), 64'(e0 + 32'd2));

    // en dropped at the start of a pass: finish it, then park in IDLE
    en = 1'b0;
    wait_passes(1, 60);
    check("en_idle", 64'(state_value), 64'd0);
    p0 = pass_count;
    repeat (5) tick();
    check("en_hold", 64'({state_value, m_axi_awvalid, pass_count}), 64'({3'd0, 1'b0, p0}));
    calib_done = 1'b0; en = 1'b1;
    repeat (3) tick();
    check("calib_low", 64'(state_value), 64'd0);
    calib_done = 1'b1;
    wait_state(3'd2, 20);

    // asynchronous reset in the middle of a write beat
    rst = 1'b0;
    #1;
    check("arst_hs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check("arst_state", 64'(state_value), 64'd0);
    @(negedge clk);
    #2 rst = 1'b1; rd5_seen = 1'b0; inj_corrupt = 1'b1;
    tick();
    check("arst_restart", 64'({state_value, m_axi_awaddr}), 64'({3'd1, 29'h0}));
    check("arst_cnt", 64'({pass_count, err_count}), 64'd0);

    // bit 0 of beat 5 flipped on readback in pass 0
    for (int c = 0; c < 60 && !rd5_seen; c++) tick();
    tick();
    check("corrupt_rdata", 64'(last_rdata), 64'h4);
    check("corrupt_err", 64'(err_count), 64'd1);
    wait_passes(1, 60);
    inj_corrupt = 1'b0;
    check("corrupt_pass", 64'(err_count), 64'd1);
    wait_passes(1, 60);
    check("clean_pass", 64'(err_count), 64'd1);
    check("pass_total", 64'(pass_count), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_tester.md
# axi_mem_tester

Parametrised AXI4 burst master that continuously exercises the DDR3 memory controller's AXI slave port. It writes a pass-dependent pattern over a configurable address window in INCR bursts, reads the window back, and checks every beat. It keeps pass and error counts for the board display. It sits between the memory controller's `ui_clk` domain and the status/seven-segment logic.

## Interface
- `ADDR_W`, 29: AXI address width.
- `DATA_W`, 32: AXI data width; power of two, 8..256.
- `BURST_LEN`, 4: beats per burst, 1..256.
- `BASE_ADDR`, 0: byte address of the window start; aligned to `BURST_LEN*DATA_W/8`.
- `WORDS`, 1024: window size in beats; a nonzero multiple of `BURST_LEN`.

Ports:
- `clk` in 1: the controller's `ui_clk`.
- `rst` in 1: **asynchronous, active-low** reset.
- `en` in 1: run enable.
- `calib_done` in 1: controller `init_calib_complete`.
- `m_axi_awaddr` out `ADDR_W`, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2, `m_axi_awvalid` out 1, `m_axi_awready` in 1.
- `m_axi_wdata` out `DATA_W`, `m_axi_wstrb` out `DATA_W/8`, `m_axi_wlast` out 1, `m_axi_wvalid` out 1, `m_axi_wready` in 1.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1.
- `m_axi_araddr` out `ADDR_W`, `m_axi_arlen` out 8, `m_axi_arsize` out 3, `m_axi_arburst` out 2, `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in `DATA_W`, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1.
- `pass_count` out 32: completed passes.
- `err_count` out 32: saturating error count.
- `last_rdata` out `DATA_W`: most recent accepted read beat.
- `state_value` out 3: current FSM state.

## Operation
- Constant outputs: `awlen`/`arlen` = `BURST_LEN-1`; `awsize`/`arsize` = log2(`DATA_W/8`); `awburst`/`arburst` = INCR (2'b01); `wstrb` = all ones.
- Pattern for beat i (0..`WORDS-1`) in pass p: `(i + p*0x01010101)` truncated or zero-extended to `DATA_W`.
- Burst k address: `BASE_ADDR + k*BURST_LEN*(DATA_W/8)`.
- States:
  - S_IDLE=0
  - S_AW=1
  - S_W=2
  - S_B=3
  - S_AR=4
  - S_R=5
- Transitions:
  - IDLE→AW when `en & calib_done`; clear beat and burst indices.
  - AW→W on `awready`.
  - W→B on the last beat accepted.
  - B→AW on `bvalid` if write bursts remain, else B→AR with burst index cleared.
  - AR→R on `arready`.
  - R→AR on the last beat if read bursts remain.
  - Otherwise R→AW, or R→IDLE if `en` is low. Either way, `pass_count` increments.
- Errors (each adds 1, saturating at 0xFFFFFFFF):
  - a read beat whose data does not equal the pattern;
  - `rresp` ≠ OKAY;
  - `rlast` value ≠ (beat == `BURST_LEN-1`);
  - `bresp` ≠ OKAY.
- At most one increment per cycle.
- `en` falling mid-pass: the current pass completes; no burst is abandoned.
- `calib_done` falling mid-pass is ignored. It is sampled only in IDLE.

## Timing
- Reset values: all valids, `bready`, `rready`, `wlast` 0; addresses and `wdata` 0; counters 0; `last_rdata` 0; `state_value` 0.
- `awvalid` = (state==AW), `wvalid` = (state==W), `bready` = (state==B), `arvalid` = (state==AR), `rready` = (state==R). All are registered-state decodes; none depend combinationally on ready.
- Address, data and `wlast` hold stable while valid is high and ready is low.
- `wlast` is high exactly on beat `BURST_LEN-1`. The next beat's data appears the cycle after a `wvalid&wready` handshake.
- Read compare happens in the cycle of `rvalid&rready`. `err_count` and `last_rdata` update on the following edge.
- Minimum write burst: 1 + `BURST_LEN` + 1 cycles with always-ready slave. Minimum read burst: 1 + `BURST_LEN`.
- Asynchronous reset mid-burst forces IDLE and all valids low immediately.
- `pass_count` wraps from 0xFFFFFFFF to 0.

## Structure
- Shared `axi_pkg` holds:
  - burst encodings (FIXED/INCR/WRAP);
  - resp encodings (OKAY/EXOKAY/SLVERR/DECERR);
  - the `mem_test_pattern(i, p)` function;
  - the state localparams.
- One sub-module is natural: `axi_beat_counter`, the beat/burst index counter with last-beat and last-burst flags. It is reused by the W and R phases.

## Test plan
- `DATA_W`=32, `BURST_LEN`=4, `WORDS`=8, always-ready memory model, `en`=1: two write bursts at 0x0 and 0x10 with data 0..7, then reads back; `pass_count`=1 and `err_count`=0 after the first pass. Pass 2 writes 0x01010101..0x01010108.
- Random `awready`/`wready`/`arready`/`rvalid` stalls (50%): AXI stability checker passes, `err_count`=0 after 10 passes.
- Memory model flips bit 0 of beat 5 on readback: `err_count`=1 per pass; `last_rdata` shows the corrupted value 0x00000004.
- Slave returns `bresp`=SLVERR on burst 1 and drops `rlast` on one burst: `err_count` increments by exactly 2 in that pass.
- `en` dropped during the write phase: the pass completes through the read phase, the FSM returns to IDLE, `pass_count`+1. `calib_done`=0 with `en`=1 keeps the FSM in IDLE.
- `rst` asserted asynchronously mid-W beat: all valids go to 0 before the next edge; after release with `en`=1 the burst restarts from `BASE_ADDR` with counters at 0.
